// File: rtl/serial_frame_aligner.sv
// Serial frame aligner: hunts for a 16-bit sync word on a raw serial line and
// emits MSB-first 16-bit payload words of fixed-length frames as FIFO writes.
module serial_frame_aligner #(
    parameter logic [15:0] SYNC_WORD   = 16'hA55A,
    parameter int          FRAME_WORDS = 8
) (
    input  logic        ti_clk,
    input  logic        reset,
    input  logic        serial_in,
    input  logic        enable,
    input  logic        fifo_full,
    output logic [15:0] word_out,
    output logic        word_valid,
    output logic        locked,
    output logic [15:0] frame_count,
    output logic [15:0] drop_count,
    output logic [7:0]  sync_loss_count,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    localparam logic [7:0] LAST_WORD = 8'(FRAME_WORDS - 1);

    state_t      state, state_n;
    logic [15:0] sr, sr_n, next_sr;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  word_cnt, word_cnt_n;
    logic [15:0] word_out_n, frame_count_n, drop_count_n;
    logic [7:0]  sync_loss_count_n;
    logic        word_valid_n, locked_n;

    assign next_sr   = {sr[14:0], serial_in};
    assign state_dbg = state;

    // FIFO write handshake: word_valid is a one-cycle write strobe with word_out
    // as data; it is only raised when fifo_full was low on the completing edge,
    // otherwise the word is counted in drop_count and discarded (no retry).
    always_comb begin
        state_n           = state;
        sr_n              = sr;
        bit_cnt_n         = bit_cnt;
        word_cnt_n        = word_cnt;
        word_out_n        = word_out;
        word_valid_n      = 1'b0;
        locked_n          = locked;
        frame_count_n     = frame_count;
        drop_count_n      = drop_count;
        sync_loss_count_n = sync_loss_count;

        if (enable) begin
            sr_n = next_sr;
            unique case (state)
                HUNT: begin
                    if (next_sr == SYNC_WORD) begin
                        state_n    = PAYLOAD;
                        bit_cnt_n  = 4'd0;
                        word_cnt_n = 8'd0;
                        locked_n   = 1'b1;
                    end
                end
                PAYLOAD: begin
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) begin
                        if (!fifo_full) begin
                            word_out_n   = next_sr;
                            word_valid_n = 1'b1;
                        end else if (drop_count != 16'hFFFF) begin
                            drop_count_n = drop_count + 16'd1;
                        end
                        word_cnt_n = word_cnt + 8'd1;
                        if (word_cnt == LAST_WORD) begin
                            state_n       = CHECK;
                            frame_count_n = frame_count + 16'd1;
                        end
                    end
                end
                CHECK: begin
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) begin
                        if (next_sr == SYNC_WORD) begin
                            state_n    = PAYLOAD;
                            word_cnt_n = 8'd0;
                        end else begin
                            // Failed bits remain in sr and seed the next hunt compare.
                            state_n  = HUNT;
                            locked_n = 1'b0;
                            if (sync_loss_count != 8'hFF)
                                sync_loss_count_n = sync_loss_count + 8'd1;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            state           <= HUNT;
            sr              <= 16'd0;
            bit_cnt         <= 4'd0;
            word_cnt        <= 8'd0;
            word_out        <= 16'd0;
            word_valid      <= 1'b0;
            locked          <= 1'b0;
            frame_count     <= 16'd0;
            drop_count      <= 16'd0;
            sync_loss_count <= 8'd0;
        end else begin
            state           <= state_n;
            sr              <= sr_n;
            bit_cnt         <= bit_cnt_n;
            word_cnt        <= word_cnt_n;
            word_out        <= word_out_n;
            word_valid      <= word_valid_n;
            locked          <= locked_n;
            frame_count     <= frame_count_n;
            drop_count      <= drop_count_n;
            sync_loss_count <= sync_loss_count_n;
        end
    end

endmodule

// File: tb/tb_serial_frame_aligner.sv
// Directed bench for serial_frame_aligner: table of frame scenarios plus
// hand-written sequences for reset, enable stall and mid-word reset.
module tb_serial_frame_aligner;

    logic        ti_clk;
    logic        reset;
    logic        serial_in;
    logic        enable;
    logic        fifo_full;
    logic [15:0] word_out;
    logic        word_valid;
    logic        locked;
    logic [15:0] frame_count;
    logic [15:0] drop_count;
    logic [7:0]  sync_loss_count;
    logic [1:0]  state_dbg;

    serial_frame_aligner dut (
        .ti_clk          (ti_clk),
        .reset           (reset),
        .serial_in       (serial_in),
        .enable          (enable),
        .fifo_full       (fifo_full),
        .word_out        (word_out),
        .word_valid      (word_valid),
        .locked          (locked),
        .frame_count     (frame_count),
        .drop_count      (drop_count),
        .sync_loss_count (sync_loss_count),
        .state_dbg       (state_dbg)
    );

    // clock / reset
    initial ti_clk = 1'b0;
    always #5 ti_clk = ~ti_clk;

    int unsigned cyc = 0;
    always @(posedge ti_clk) cyc <= cyc + 1;

    // scoreboard
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    int          exp_gap_q[$];
    int unsigned last_valid_cyc = 0;
    int          prev_slot = 0;
    bit          have_prev = 0;
    logic [15:0] last_exp = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge ti_clk) begin
        if (word_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: got word %0h expected no pulse", word_out);
            end else begin
                logic [15:0] ew;
                int          eg;
                ew = exp_q.pop_front();
                eg = exp_gap_q.pop_front();
                check("word_out", word_out, ew);
                if (eg != 0) check("pulse_gap", cyc - last_valid_cyc, eg);
            end
            last_valid_cyc = cyc;
        end
    end

    // driver tasks
    task automatic drive_bit(input logic b, input logic f);
        serial_in = b;
        fifo_full = f;
        enable    = 1'b1;
        @(posedge ti_clk);
        #1;
        fifo_full = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input bit full_on_last);
        for (int i = 15; i >= 0; i--) drive_bit(w[i], (i == 0) && full_on_last);
    endtask

    task automatic send_junk();
        logic [4:0] junk;
        junk = 5'b10110;
        for (int i = 4; i >= 0; i--) drive_bit(junk[i], 1'b0);
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        repeat (n) @(posedge ti_clk);
        #1;
    endtask

    // slot = 16-bit position in the stream after the lock, used to derive pulse spacing
    task automatic expect_word(input logic [15:0] w, input int slot);
        exp_q.push_back(w);
        exp_gap_q.push_back(have_prev ? 16 * (slot - prev_slot) : 0);
        prev_slot = slot;
        have_prev = 1;
        last_exp  = w;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b1;
        repeat (3) begin
            serial_in = 1'($urandom_range(0, 1));
            @(posedge ti_clk);
            #1;
        end
        reset = 1'b0;
        exp_q.delete();
        exp_gap_q.delete();
        have_prev = 0;
    endtask

    typedef struct {
        logic [15:0] check_word;
        int          full_idx;
        logic [15:0] exp_frames;
        logic [15:0] exp_drops;
        logic [7:0]  exp_loss;
        logic        exp_locked;
    } scen_t;

    scen_t scen[4];

    initial begin
        logic [15:0] win;
        logic        b;
        int unsigned mark;
        logic [15:0] w8001;
        logic [15:0] w3;

        scen[0] = '{check_word: 16'hA55A, full_idx: 0, exp_frames: 16'd1, exp_drops: 16'd0, exp_loss: 8'd0, exp_locked: 1'b1};
        scen[1] = '{check_word: 16'hA55A, full_idx: 3, exp_frames: 16'd1, exp_drops: 16'd1, exp_loss: 8'd0, exp_locked: 1'b1};
        scen[2] = '{check_word: 16'h0000, full_idx: 0, exp_frames: 16'd1, exp_drops: 16'd0, exp_loss: 8'd1, exp_locked: 1'b1};
        scen[3] = '{check_word: 16'hA55A, full_idx: 8, exp_frames: 16'd1, exp_drops: 16'd1, exp_loss: 8'd0, exp_locked: 1'b1};

        reset     = 1'b1;
        serial_in = 1'b0;
        enable    = 1'b0;
        fifo_full = 1'b0;

        // reset with a toggling line, then random data that never forms the sync word
        do_reset();
        reset = 1'b1;
        #1;
        check("rst_word_out", word_out, 16'd0);
        check("rst_word_valid", word_valid, 1'b0);
        check("rst_locked", locked, 1'b0);
        check("rst_frames", frame_count, 16'd0);
        check("rst_drops", drop_count, 16'd0);
        check("rst_loss", sync_loss_count, 8'd0);
        check("rst_state", state_dbg, 2'd0);
        reset = 1'b0;
        win = 16'd0;
        for (int i = 0; i < 100; i++) begin
            b = 1'($urandom_range(0, 1));
            if ({win[14:0], b} == 16'hA55A) b = ~b;
            win = {win[14:0], b};
            drive_bit(b, 1'b0);
        end
        idle(2);
        check("rand_locked", locked, 1'b0);
        check("rand_state", state_dbg, 2'd0);

        // table-driven frame scenarios
        for (int s = 0; s < 4; s++) begin
            do_reset();
            send_junk();
            send_word(16'hA55A, 1'b0);
            for (int i = 1; i <= 8; i++) begin
                if (scen[s].full_idx != i) expect_word(16'(i), i);
                send_word(16'(i), scen[s].full_idx == i);
            end
            if (scen[s].check_word == 16'hA55A) begin
                send_word(16'hA55A, 1'b0);
                expect_word(16'h1111, 10);
                send_word(16'h1111, 1'b0);
            end else begin
                for (int i = 15; i >= 1; i--) drive_bit(scen[s].check_word[i], 1'b0);
                check("lock_before_last_check_bit", locked, 1'b1);
                drive_bit(scen[s].check_word[0], 1'b0);
                check("lock_after_failed_check", locked, 1'b0);
                check("loss_after_failed_check", sync_loss_count, 8'd1);
                send_word(16'h1111, 1'b0);
                check("still_hunting", state_dbg, 2'd0);
                send_word(16'hA55A, 1'b0);
                expect_word(16'h2222, 12);
                send_word(16'h2222, 1'b0);
            end
            idle(2);
            check("pending_words", exp_q.size(), 0);
            check("frame_count", frame_count, scen[s].exp_frames);
            check("drop_count", drop_count, scen[s].exp_drops);
            check("sync_loss_count", sync_loss_count, scen[s].exp_loss);
            check("locked", locked, scen[s].exp_locked);
            check("word_out_hold", word_out, last_exp);
        end

        // enable low for 10 cycles after bit 7 of 0x8001
        do_reset();
        send_junk();
        send_word(16'hA55A, 1'b0);
        mark = cyc;
        w8001 = 16'h8001;
        expect_word(w8001, 1);
        for (int i = 15; i >= 9; i--) drive_bit(w8001[i], 1'b0);
        idle(10);
        for (int i = 8; i >= 0; i--) drive_bit(w8001[i], 1'b0);
        idle(2);
        check("stall_pending", exp_q.size(), 0);
        check("stall_latency", last_valid_cyc - mark, 26);
        check("stall_word_out", word_out, 16'h8001);

        // reset after bit 9 of the third payload word
        do_reset();
        send_junk();
        send_word(16'hA55A, 1'b0);
        expect_word(16'h0001, 1);
        send_word(16'h0001, 1'b0);
        expect_word(16'h0002, 2);
        send_word(16'h0002, 1'b0);
        w3 = 16'h0003;
        for (int i = 15; i >= 7; i--) drive_bit(w3[i], 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_word_out", word_out, 16'd0);
        check("midrst_word_valid", word_valid, 1'b0);
        check("midrst_locked", locked, 1'b0);
        check("midrst_state", state_dbg, 2'd0);
        check("midrst_drops", drop_count, 16'd0);
        check("midrst_loss", sync_loss_count, 8'd0);
        @(posedge ti_clk);
        #1;
        reset = 1'b0;
        check("midrst_pending", exp_q.size(), 0);
        have_prev = 0;
        for (int i = 6; i >= 0; i--) drive_bit(w3[i], 1'b0);
        send_word(16'h1234, 1'b0);
        send_word(16'h5678, 1'b0);
        check("midrst_unlocked", locked, 1'b0);
        send_word(16'hA55A, 1'b0);
        expect_word(16'h4321, 1);
        send_word(16'h4321, 1'b0);
        idle(2);
        check("midrst_resume_pending", exp_q.size(), 0);
        check("midrst_resume_word", word_out, 16'h4321);
        check("midrst_frames", frame_count, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_frame_aligner.md
# serial_frame_aligner

Upstream stage of the aptamer data-streaming path. It samples the raw serial line on the host interface clock, hunts for a 16-bit sync word, and assembles fixed-length frames of MSB-first 16-bit payload words. Each completed word is pushed into the 16-bit streaming FIFO with a single-cycle write strobe; the FIFO is drained by the host pipe-out endpoint. Status counters expose frames, FIFO-full drops and sync losses for wire-out readback.

## Interface

Parameters:
- SYNC_WORD, 16'hA55A: frame delimiter, compared MSB-first.
- FRAME_WORDS, 8: payload words per frame (legal range 1..255).

Ports:
- ti_clk  in  1  single clock for the block; all sampling on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- serial_in  in  1  raw serial data, one bit per enabled ti_clk cycle, MSB first.
- enable  in  1  bit-enable; low freezes all state.
- fifo_full  in  1  FIFO full flag; suppresses the write when high.
- word_out  out  16  assembled payload word; FIFO din.
- word_valid  out  1  one-cycle FIFO wr_en.
- locked  out  1  high while frame-aligned (PAYLOAD or CHECK).
- frame_count  out  16  completed frames; wraps at 16'hFFFF -> 0.
- drop_count  out  16  words lost to fifo_full; saturates at 16'hFFFF.
- sync_loss_count  out  8  sync-check failures; saturates at 8'hFF.

## Operation

- Shift register sr[15:0]: when enable is high, sr <= {sr[14:0], serial_in}. Define next = {sr[14:0], serial_in}.
- States: HUNT, PAYLOAD, CHECK. Also bit_cnt (4 bits) and word_cnt (8 bits).
- HUNT: bit-by-bit sliding compare. When next == SYNC_WORD, go to PAYLOAD, clear bit_cnt and word_cnt, and set locked. Bits preceding the match are discarded.
- PAYLOAD: bit_cnt increments on each enabled cycle. At bit_cnt == 15 the word is complete:
  - If fifo_full == 0: word_out <= next and word_valid <= 1.
  - Otherwise: drop_count increments (saturating) and word_out holds its value.
  - word_cnt increments. If word_cnt == FRAME_WORDS-1, go to CHECK and increment frame_count.
  - A sync pattern appearing inside the payload is ignored.
- CHECK: collect 16 bits. At bit_cnt == 15:
  - If next == SYNC_WORD: go to PAYLOAD with word_cnt = 0.
  - Otherwise: go to HUNT, clear locked, and increment sync_loss_count (saturating). The mismatched bits stay in sr and take part in the HUNT compare on the next enabled cycle.
- A drop and a frame completion in the same cycle: both counters update.
- enable low: sr, counters, state and bit_cnt all hold. word_valid is 0.
- Reset: state = HUNT. sr, bit_cnt, word_cnt, word_out, word_valid, locked, frame_count, drop_count and sync_loss_count all clear to 0. The FIFO is reset separately.

## Timing

- All outputs are registered. word_valid and the new word_out update on the same edge that samples bit 16 of the word, and are visible for exactly one cycle after that edge.
- word_out holds its value after word_valid drops.
- fifo_full is sampled on that same edge. No retry: a dropped word is lost.
- With enable held high, word_valid pulses are exactly 16 cycles apart within a frame. Between the last word of one frame and the first word of the next there are 32 cycles (16 sync bits plus 16 payload bits).
- locked rises on the edge that samples the last sync bit in HUNT. It falls on the edge that samples the last bit of a failed check.
- The first payload bit is the bit sampled on the enabled edge after lock.
- Asserting reset mid-word abandons the partial word; no word_valid is generated for it.

## Test plan

1. Reset with serial_in toggling -> all outputs 0, locked 0, no word_valid for 100 cycles of random data that excludes 16'hA55A.
2. Stream 5 junk bits, then A55A, then words 0x0001..0x0008, then A55A, then 0x1111 -> eight word_valid pulses carrying 0x0001..0x0008, 16 cycles apart. frame_count = 1, locked stays 1, and the next pulse carries 0x1111.
3. Same stream with fifo_full high only on the completion edge of word 3 -> seven pulses (0x0003 missing), drop_count = 1, frame_count = 1.
4. Valid frame followed by 0x0000 instead of the sync word -> locked falls at bit 16 of the check, sync_loss_count = 1, no word_valid until a fresh A55A, then normal capture resumes.
5. Drop enable for 10 cycles after bit 7 of word 0x8001 -> word_out = 0x8001 with word_valid delayed by exactly 10 cycles.
6. Assert reset after bit 9 of the third payload word -> all outputs 0 asynchronously and state HUNT. Payload bits sent after the release of reset produce no word_valid until A55A is seen.
